// File: rtl/decode_3to8.sv
// Registered binary-to-one-hot decoder with enable and valid qualifier.
// Optional macro DEC_INREG_EN adds an input register stage (latency 1 -> 2 clocks).
module decode_3to8 #(
    parameter int IN_W        = 3,
    parameter bit OUT_ACT_LOW = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [IN_W-1:0]      In,
    output logic [(2**IN_W)-1:0] Out,
    output logic                 valid
);

    localparam int               OUT_W = 2**IN_W;
    localparam logic [OUT_W-1:0] IDLE  = {OUT_W{OUT_ACT_LOW}};

    logic [IN_W-1:0]  code;
    logic             dec_en;
    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] out_d, out_q;
    logic             valid_d, valid_q;

`ifdef DEC_INREG_EN
    logic [IN_W-1:0] code_q;
    logic            en_d, en_q;

    always_comb begin
        en_d = en;
    end

    // NOTE: the code register carries no reset; en_q is reset and fully gates its use,
    // so stale or unknown codes never reach Out.
    always_ff @(posedge clk) begin
        code_q <= In;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en_d;
        end
    end

    assign code   = code_q;
    assign dec_en = en_q;
`else
    assign code   = In;
    assign dec_en = en;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        onehot  = '0;
        out_d   = IDLE;
        valid_d = 1'b0;
        if (dec_en) begin
            onehot[code] = 1'b1;
            out_d        = OUT_ACT_LOW ? ~onehot : onehot;
            valid_d      = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= IDLE;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign Out   = out_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_decode_3to8.sv
// Self-checking bench for decode_3to8: history-based model compared every cycle,
// plus directed literal checks; runs active-high and active-low instances side by side.
module tb_decode_3to8;

`ifdef DEC_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       en      = 1'b0;
    logic [2:0] in_code = 3'd0;
    logic [7:0] out_h, out_l;
    logic       valid_h, valid_l;

    int n_cmp = 0;
    int n_err = 0;
    bit armed = 1'b0;

    // Input history, index 0 = sample taken at the most recent rising edge.
    logic       h_rst[$];
    logic       h_en[$];
    logic [2:0] h_in[$];

    logic       m_valid;
    logic [7:0] m_out;
    bit         m_known;

    logic [7:0] sweep_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    always #5 clk = ~clk;

    decode_3to8 #(.IN_W(3), .OUT_ACT_LOW(1'b0)) dut_h (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .In   (in_code),
        .Out  (out_h),
        .valid(valid_h)
    );

    decode_3to8 #(.IN_W(3), .OUT_ACT_LOW(1'b1)) dut_l (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .In   (in_code),
        .Out  (out_l),
        .valid(valid_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    always @(posedge clk) begin
        h_rst.push_front(rst_n);
        h_en.push_front(en);
        h_in.push_front(in_code);
        if (h_rst.size() > 4) begin
            void'(h_rst.pop_back());
            void'(h_en.pop_back());
            void'(h_in.pop_back());
        end
    end

    // A result is valid when reset was high on every edge of its LAT-edge path and
    // en was high at the edge that first captured it.
    always @(negedge clk) begin
        if (armed) begin
            m_known = 1'b1;
            m_valid = 1'b0;
            if (h_rst[0] == 1'b0) begin
                m_valid = 1'b0;
            end else if (h_rst.size() < LAT) begin
                m_known = 1'b0;
            end else begin
                m_valid = h_en[LAT-1];
                for (int j = 0; j < LAT; j++) m_valid = m_valid & h_rst[j];
            end
            if (m_known) begin
                m_out = m_valid ? (8'd1 << h_in[LAT-1]) : 8'd0;
                check("model_out_h",   {24'd0, out_h},   {24'd0, m_out});
                check("model_valid_h", {31'd0, valid_h}, {31'd0, m_valid});
                check("model_out_l",   {24'd0, out_l},   {24'd0, ~m_out});
                check("model_valid_l", {31'd0, valid_l}, {31'd0, m_valid});
                if (m_valid) check("onehot_count", $countones(out_h), 32'd1);
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        in_code = 3'd5;
        tick(1);
        armed = 1'b1;
        tick(1);
        check("reset_out",     {24'd0, out_h},   32'h00);
        check("reset_valid",   {31'd0, valid_h}, 32'd0);
        check("reset_out_low", {24'd0, out_l},   32'hFF);

        rst_n = 1'b1;
        tick(LAT);
        check("release_out",   {24'd0, out_h},   32'h20);
        check("release_valid", {31'd0, valid_h}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            in_code = 3'(i);
            tick(LAT);
            check("sweep_out", {24'd0, out_h}, {24'd0, sweep_exp[i]});
            tick(10 - LAT);
        end

        in_code = 3'd3;
        tick(LAT);
        check("en_on_out", {24'd0, out_h}, 32'h08);
        en = 1'b0;
        tick(LAT);
        check("en_off_out",   {24'd0, out_h},   32'h00);
        check("en_off_valid", {31'd0, valid_h}, 32'd0);
        en = 1'b1;
        tick(LAT);
        check("en_again_out", {24'd0, out_h}, 32'h08);

        in_code = 3'd6;
        tick(LAT);
        check("pre_rst_out", {24'd0, out_h}, 32'h40);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_out",   {24'd0, out_h},   32'h00);
        check("mid_rst_valid", {31'd0, valid_h}, 32'd0);
        rst_n = 1'b1;
        tick(LAT);
        check("post_rst_out", {24'd0, out_h}, 32'h40);

        in_code = 3'd2;
        tick(LAT);
        check("act_low_out", {24'd0, out_l}, 32'hFB);

        en = 1'b0;
        tick(3);
        en      = 1'b1;
        in_code = 3'd7;
        tick(1);
`ifdef DEC_INREG_EN
        check("inreg_n_out", {24'd0, out_h}, 32'h00);
        tick(1);
`endif
        check("lat_out",   {24'd0, out_h},   32'h80);
        check("lat_valid", {31'd0, valid_h}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            in_code = 3'($urandom_range(0, 7));
            en      = 1'($urandom_range(0, 1));
            tick(1);
        end

        armed = 1'b0;
        tick(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
